// File: rtl/eight_three_encoder.sv
// Sequential 8-to-3 event encoder: captures rising edges on i0..i7, queues them, issues indices over valid/ack.
// Optional round-robin arbitration: define EIGHT_THREE_ENCODER_ROUND_ROBIN_EN (default: fixed priority, i7 highest).
module eight_three_encoder (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic ack,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic valid,
    output logic drop
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [7:0] in_vec;
    logic [7:0] prev;
    logic [7:0] pend, pend_next;
    logic [7:0] rise, set_mask, clr_mask;
    logic [2:0] code, code_next;
    logic [2:0] winner;
    logic       has_winner;
    logic       issue;
    logic       valid_next;
    logic       drop_next;

    assign in_vec = {i7, i6, i5, i4, i3, i2, i1, i0};

`ifdef EIGHT_THREE_ENCODER_ROUND_ROBIN_EN
    logic [2:0] last, last_next;

    // Search upward from last+1 with wrap; the first pending index found wins.
    always_comb begin
        logic [2:0] idx;
        winner     = '0;
        has_winner = 1'b0;
        for (int off = 1; off <= 8; off++) begin
            idx = last + 3'(off);
            if (!has_winner && pend[idx]) begin
                winner     = idx;
                has_winner = 1'b1;
            end
        end
    end

    assign last_next = issue ? winner : last;
`else
    // Fixed priority: later iterations overwrite, so the highest pending index wins.
    always_comb begin
        winner     = '0;
        has_winner = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (pend[k]) begin
                winner     = 3'(k);
                has_winner = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        issue      = 1'b0;
        state_next = state;
        code_next  = code;

        rise      = in_vec & ~prev;
        set_mask  = en ? rise : 8'h00;
        drop_next = en & (|(rise & pend));

        unique case (state)
            IDLE: issue = en & has_winner;
            HOLD: begin
                if (ack) begin
                    issue = en & has_winner;
                    if (!issue) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue) begin
            state_next = HOLD;
            code_next  = winner;
        end
        valid_next = (state_next == HOLD);

        // A new edge on the bit being cleared keeps it pending: the OR with set_mask comes last.
        clr_mask  = issue ? (8'h01 << winner) : 8'h00;
        pend_next = (pend & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state <= IDLE;
            prev  <= '0;
            pend  <= '0;
            code  <= '0;
            valid <= 1'b0;
            drop  <= 1'b0;
`ifdef EIGHT_THREE_ENCODER_ROUND_ROBIN_EN
            last  <= 3'd7;
`endif
        end else begin
            state <= state_next;
            prev  <= in_vec;
            pend  <= pend_next;
            code  <= code_next;
            valid <= valid_next;
            drop  <= drop_next;
`ifdef EIGHT_THREE_ENCODER_ROUND_ROBIN_EN
            last  <= last_next;
`endif
        end
    end

    assign {y2, y1, y0} = code;

endmodule

// File: tb/tb_eight_three_encoder.sv
// Directed self-checking bench for eight_three_encoder; expected values are hand-derived.
// Arbitration-order expectations follow EIGHT_THREE_ENCODER_ROUND_ROBIN_EN when it is defined.
module tb_eight_three_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ack;
    logic [7:0] i_vec;
    logic       y0, y1, y2;
    logic       valid;
    logic       drop;
    logic [2:0] y;

    int checks = 0;
    int errors = 0;

    assign y = {y2, y1, y0};

    always #5 clk = ~clk;

    eight_three_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i0    (i_vec[0]),
        .i1    (i_vec[1]),
        .i2    (i_vec[2]),
        .i3    (i_vec[3]),
        .i4    (i_vec[4]),
        .i5    (i_vec[5]),
        .i6    (i_vec[6]),
        .i7    (i_vec[7]),
        .ack   (ack),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2),
        .valid (valid),
        .drop  (drop)
    );

`ifdef EIGHT_THREE_ENCODER_ROUND_ROBIN_EN
    localparam logic [2:0] ORD0 = 3'd1, ORD1 = 3'd3, ORD2 = 3'd6;
    localparam logic [2:0] FIRST_24 = 3'd2, SECOND_24 = 3'd4;
`else
    localparam logic [2:0] ORD0 = 3'd6, ORD1 = 3'd3, ORD2 = 3'd1;
    localparam logic [2:0] FIRST_24 = 3'd4, SECOND_24 = 3'd2;
`endif

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_code(input string tag, input logic [2:0] exp_code);
        check({tag, "_valid"}, 8'(valid), 8'd1);
        check({tag, "_code"}, 8'(y), 8'(exp_code));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        ack   = 1'b0;
        i_vec = 8'h00;
        tick();
        tick();
        check("rst_valid", 8'(valid), 8'd0);
        check("rst_y", 8'(y), 8'd0);
        check("rst_drop", 8'(drop), 8'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Single event on i5, held for 10 cycles without ack.
        i_vec = 8'h20;
        tick();
        i_vec = 8'h00;
        check("i5_lat1_valid", 8'(valid), 8'd0);
        tick();
        expect_code("i5_lat2", 3'd5);
        for (int n = 0; n < 10; n++) begin
            tick();
            expect_code("i5_hold", 3'd5);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("i5_ack_valid", 8'(valid), 8'd0);

        // Three simultaneous events drained back-to-back with ack held high.
        do_reset();
        i_vec = 8'h4A;
        ack   = 1'b1;
        tick();
        i_vec = 8'h00;
        check("multi_pend_valid", 8'(valid), 8'd0);
        tick();
        expect_code("multi_c0", ORD0);
        tick();
        expect_code("multi_c1", ORD1);
        tick();
        expect_code("multi_c2", ORD2);
        tick();
        check("multi_done_valid", 8'(valid), 8'd0);
        ack = 1'b0;

        // Re-edge on a still-pending bit produces one drop pulse and no duplicate.
        do_reset();
        i_vec = 8'h14;
        tick();
        i_vec = 8'h00;
        tick();
        expect_code("drop_first", FIRST_24);
        i_vec[SECOND_24] = 1'b1;
        tick();
        i_vec = 8'h00;
        check("drop_pulse", 8'(drop), 8'd1);
        tick();
        check("drop_clear", 8'(drop), 8'd0);
        expect_code("drop_held", FIRST_24);
        ack = 1'b1;
        tick();
        expect_code("drop_second", SECOND_24);
        tick();
        check("drop_no_dup", 8'(valid), 8'd0);
        ack = 1'b0;

        // en=0 keeps the held code, loses new edges, and stops issuing.
        i_vec = 8'h10;
        tick();
        i_vec = 8'h00;
        tick();
        expect_code("en_c4", 3'd4);
        i_vec = 8'h01;
        tick();
        i_vec = 8'h00;
        en    = 1'b0;
        tick();
        i_vec = 8'h80;
        tick();
        i_vec = 8'h00;
        expect_code("en_off_hold", 3'd4);
        check("en_off_drop", 8'(drop), 8'd0);
        ack = 1'b1;
        tick();
        check("en_off_ack_valid", 8'(valid), 8'd0);
        tick();
        check("en_off_idle_valid", 8'(valid), 8'd0);
        ack = 1'b0;
        en  = 1'b1;
        tick();
        expect_code("en_on_c0", 3'd0);
        ack = 1'b1;
        tick();
        check("en_no_i7", 8'(valid), 8'd0);
        tick();
        check("en_no_i7_b", 8'(valid), 8'd0);
        ack = 1'b0;

        // Level held high across reset release counts as one edge.
        rst   = 1'b1;
        i_vec = 8'h08;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("lvl_lat1_valid", 8'(valid), 8'd0);
        tick();
        expect_code("lvl_c3", 3'd3);
        ack = 1'b1;
        tick();
        check("lvl_ack_valid", 8'(valid), 8'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("lvl_no_repeat", 8'(valid), 8'd0);
        end
        ack   = 1'b0;
        i_vec = 8'h00;
        tick();
        i_vec = 8'h08;
        tick();
        tick();
        expect_code("lvl_reissue_a", 3'd3);
        i_vec = 8'h00;
        tick();
        // ack and a fresh i3 edge on the same edge: the old code retires, the new event queues.
        i_vec = 8'h08;
        ack   = 1'b1;
        tick();
        ack = 1'b0;
        check("lvl_ack_edge_valid", 8'(valid), 8'd0);
        tick();
        expect_code("lvl_reissue_b", 3'd3);
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        i_vec = 8'h00;
        check("lvl_done", 8'(valid), 8'd0);

        // Reset during HOLD with three events still pending discards everything.
        i_vec = 8'h0F;
        tick();
        i_vec = 8'h00;
        tick();
        check("rsthold_valid_pre", 8'(valid), 8'd1);
        rst = 1'b1;
        tick();
        check("rsthold_valid", 8'(valid), 8'd0);
        check("rsthold_y", 8'(y), 8'd0);
        check("rsthold_drop", 8'(drop), 8'd0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rsthold_quiet", 8'(valid), 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
